// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and oversample ratio.
// Used by the transmit controller and, later, the receive controller.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OVERSAMPLE = 16;

  // Narrower characters arrive zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_ctl.sv
// UART transmit controller: takes one character per valid/ready handshake and
// serialises start, data (LSB first), optional parity and stop bits on txd.
module uart_tx_ctl
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_x16_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam logic [3:0] OVER_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit         HAS_PAR   = (PARITY != PAR_NONE);

  uart_state_e          state, state_next;
  logic [3:0]           over_cnt, over_next;
  logic [2:0]           bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 par, par_next;
  logic                 txd_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      over_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par      <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_next;
      over_cnt <= over_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      par      <= par_next;
      txd      <= txd_next;
    end
  end

  // txd is registered from the next state so the line moves on the same edge as the FSM.
  always_comb begin
    state_next = state;
    over_next  = over_cnt;
    bit_next   = bit_cnt;
    shift_next = shift;
    par_next   = par;
    txd_next   = 1'b1;

    if (state == ST_IDLE) begin
      if (tx_valid) begin
        state_next = ST_START;
        shift_next = tx_data;
        par_next   = parity_bit(8'(tx_data), PARITY);
        over_next  = '0;
        bit_next   = '0;
      end
    end else if (baud_x16_en) begin
      over_next = over_cnt + 4'd1;
      if (over_cnt == OVER_LAST) begin
        case (state)
          ST_START: begin
            state_next = ST_DATA;
            bit_next   = '0;
          end
          ST_DATA: begin
            shift_next = shift >> 1;
            bit_next   = bit_cnt + 3'd1;
            if (bit_cnt == DATA_LAST) begin
              state_next = HAS_PAR ? ST_PARITY : ST_STOP;
              bit_next   = '0;
            end
          end
          ST_PARITY: begin
            state_next = ST_STOP;
            bit_next   = '0;
          end
          ST_STOP: begin
            bit_next = bit_cnt + 3'd1;
            if (bit_cnt == STOP_LAST) begin
              state_next = ST_IDLE;
              bit_next   = '0;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end

    case (state_next)
      ST_START:  txd_next = 1'b0;
      ST_DATA:   txd_next = shift_next[0];
      ST_PARITY: txd_next = par_next;
      default:   txd_next = 1'b1;
    endcase
  end

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = ~tx_ready;

endmodule
